stream_align: RTL and testbench

- Receive-side counterpart to the fixed-length delay lines that match pipeline latency at the producer.
- Accepts two BITSIZE-bit valid-tagged streams (A: long pipelined path, B: short bypass path) whose relative latency is unknown or variable.
- Buffers whichever stream arrives early in a per-stream FIFO and emits aligned (A,B) pairs.
- Placed at the merge point of the Level-3 datapath, ahead of the combining stage.

---
 rtl/stream_align.sv | 158 +++++++++++++++
 tb/tb_stream_align.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_align.sv
// stream_align: re-aligns two valid-tagged streams whose relative latency is
// unknown. Each stream is buffered in its own small FIFO. Whenever both FIFOs
// hold at least one word, the two heads are popped together and registered
// as an aligned (A,B) pair.
//
// Stream semantics: there is no ready signal in either direction.
//   - a_valid/b_valid mark a word present in that cycle. The word is accepted
//     unless its FIFO is full and no pop happens at the same edge, or flush is
//     high. A rejected word (other than on flush) sets the sticky overflow flag.
//   - out_valid is a one-cycle pulse per pair, and the consumer must take
//     every pulse.

// Circular FIFO with a separate occupancy count, so full and empty are never
// ambiguous. The pointers are log2(DEPTH) bits and wrap naturally, which is
// why DEPTH must be a power of two.
module stream_align_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push_en;
    logic          pop_en;

    assign full    = (count == CW'(DEPTH));
    // A pop at the same edge frees a slot, so a full FIFO can still take a word.
    assign push_en = push && !clear && (!full || pop);
    assign pop_en  = pop && !clear;
    assign head    = mem[rd_ptr];

    // Storage write. The contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Flush empties the FIFO but keeps the overflow history.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// Top level: two FIFOs plus the registered output pair.
module stream_align #(
    parameter int BITSIZE = 20,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         a_valid,
    input  logic [BITSIZE-1:0]           a_data,
    input  logic                         b_valid,
    input  logic [BITSIZE-1:0]           b_data,
    output logic                         out_valid,
    output logic [BITSIZE-1:0]           out_a,
    output logic [BITSIZE-1:0]           out_b,
    output logic [$clog2(DEPTH+1)-1:0]   a_count,
    output logic [$clog2(DEPTH+1)-1:0]   b_count,
    output logic                         overflow_a,
    output logic                         overflow_b
);
    logic [BITSIZE-1:0] a_head;
    logic [BITSIZE-1:0] b_head;
    logic               pop;

    // The pop decision uses the pre-edge counts only. A word pushed at this
    // edge is never popped at the same edge, which gives a minimum latency of
    // two edges.
    assign pop = (a_count != '0) && (b_count != '0) && !flush;

    stream_align_fifo #(
        .W     (BITSIZE),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (a_valid),
        .push_data (a_data),
        .pop       (pop),
        .head      (a_head),
        .count     (a_count),
        .overflow  (overflow_a)
    );

    stream_align_fifo #(
        .W     (BITSIZE),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (b_valid),
        .push_data (b_data),
        .pop       (pop),
        .head      (b_head),
        .count     (b_count),
        .overflow  (overflow_b)
    );

    // Output pair register. Data holds its last value between pulses and
    // across a flush. Only reset zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_a <= a_head;
                out_b <= b_head;
            end
        end
    end
endmodule

// File: tb/tb_stream_align.sv
// Bench for stream_align. A behavioural queue model predicts which words are
// accepted, when pairs pop, the counts and the overflow flags. Predicted pairs
// go into a scoreboard queue and are matched when out_valid is seen.
module tb_stream_align;
    localparam int W     = 20;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          a_valid;
    logic [W-1:0]  a_data;
    logic          b_valid;
    logic [W-1:0]  b_data;
    logic          out_valid;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;
    logic          overflow_a;
    logic          overflow_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    logic [W-1:0]   a_mq[$];
    logic [W-1:0]   b_mq[$];
    logic [2*W-1:0] exp_q[$];
    logic           exp_valid = 1'b0;
    logic [W-1:0]   exp_oa    = '0;
    logic [W-1:0]   exp_ob    = '0;
    logic           exp_ovf_a = 1'b0;
    logic           exp_ovf_b = 1'b0;

    stream_align #(
        .BITSIZE (W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .out_valid  (out_valid),
        .out_a      (out_a),
        .out_b      (out_b),
        .a_count    (a_count),
        .b_count    (b_count),
        .overflow_a (overflow_a),
        .overflow_b (overflow_b)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic fl,
                        input logic av, input logic [W-1:0] ad,
                        input logic bv, input logic [W-1:0] bd);
        logic           pop;
        logic           acc_a;
        logic           acc_b;
        logic [2*W-1:0] pair;
        rst     = r;
        flush   = fl;
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        if (r) begin
            a_mq.delete();
            b_mq.delete();
            exp_q.delete();
            exp_valid = 1'b0;
            exp_oa    = '0;
            exp_ob    = '0;
            exp_ovf_a = 1'b0;
            exp_ovf_b = 1'b0;
        end else if (fl) begin
            a_mq.delete();
            b_mq.delete();
            exp_valid = 1'b0;
        end else begin
            pop   = (a_mq.size() > 0) && (b_mq.size() > 0);
            acc_a = av && ((a_mq.size() < DEPTH) || pop);
            acc_b = bv && ((b_mq.size() < DEPTH) || pop);
            if (av && !acc_a) exp_ovf_a = 1'b1;
            if (bv && !acc_b) exp_ovf_b = 1'b1;
            exp_valid = pop;
            if (pop) begin
                exp_oa = a_mq.pop_front();
                exp_ob = b_mq.pop_front();
                exp_q.push_back({exp_oa, exp_ob});
            end
            if (acc_a) a_mq.push_back(ad);
            if (acc_b) b_mq.push_back(bd);
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, exp_valid);
        if (out_valid) begin
            check("pair_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                pair = exp_q.pop_front();
                check("pair", {out_a, out_b}, pair);
            end
        end
        check("out_a_hold", out_a, exp_oa);
        check("out_b_hold", out_b, exp_ob);
        check("a_count", a_count, a_mq.size());
        check("b_count", b_count, b_mq.size());
        check("overflow_a", overflow_a, exp_ovf_a);
        check("overflow_b", overflow_b, exp_ovf_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    task automatic push_a(input logic [W-1:0] d);
        step(0, 0, 1, d, 0, '0);
    endtask

    task automatic push_b(input logic [W-1:0] d);
        step(0, 0, 0, '0, 1, d);
    endtask

    initial begin
        // Reset with random inputs, then idle.
        for (int i = 0; i < 2; i++) begin
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
                 1'($urandom_range(0, 1)), W'($urandom));
        end
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_a_count", a_count, 0);
        idle(3);

        // Zero skew: both words at edge k, pair after edge k+1.
        step(0, 0, 1, 20'h00011, 1, 20'h00022);
        check("zero_skew_no_bypass", out_valid, 1'b0);
        idle(1);
        check("zero_skew_valid", out_valid, 1'b1);
        check("zero_skew_a", out_a, 20'h00011);
        check("zero_skew_b", out_b, 20'h00022);
        idle(1);
        check("zero_skew_pulse", out_valid, 1'b0);

        // Skew 3: A leads B by three words.
        push_a(20'h1);
        push_a(20'h2);
        push_a(20'h3);
        check("skew_peak", a_count, 3);
        push_b(20'hA);
        push_b(20'hB);
        push_b(20'hC);
        idle(3);
        check("skew_drained", a_count, 0);

        // Overflow: word 5 dropped, then four pairs with A=1..4.
        for (int i = 1; i <= 5; i++) push_a(W'(i));
        check("ovf_set", overflow_a, 1'b1);
        check("ovf_full", a_count, DEPTH);
        for (int i = 0; i < 4; i++) push_b(W'(20'h100 + i));
        idle(3);
        check("ovf_sticky", overflow_a, 1'b1);

        // Full plus pop: the full FIFO accepts A=9 on a pop edge.
        step(1, 0, 0, '0, 0, '0);
        push_a(20'h1);
        push_a(20'h2);
        push_a(20'h3);
        step(0, 0, 1, 20'h4, 1, 20'h201);
        step(0, 0, 1, 20'h9, 1, 20'h202);
        check("full_pop_count", a_count, DEPTH);
        check("full_pop_no_ovf", overflow_a, 1'b0);
        for (int i = 0; i < 3; i++) push_b(W'(20'h203 + i));
        idle(3);

        // Flush mid-operation, then a fresh pair with the normal latency.
        push_a(20'h31);
        push_a(20'h32);
        step(0, 1, 1, 20'h33, 0, '0);
        check("flush_a_count", a_count, 0);
        check("flush_out_valid", out_valid, 1'b0);
        step(0, 0, 1, 20'h55, 1, 20'h66);
        idle(1);
        check("post_flush_pair", {out_a, out_b}, {20'h55, 20'h66});
        idle(2);

        // Random traffic with drifting skew and occasional flush.
        for (int i = 0; i < 600; i++) begin
            int pa;
            int pb;
            pa = ((i / 60) % 2 == 0) ? 70 : 35;
            pb = 105 - pa;
            step(0, 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 99) < pa), W'($urandom),
                 1'($urandom_range(0, 99) < pb), W'($urandom));
        end
        idle(DEPTH + 2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
